// File: rtl/trace_write_arbiter.sv
// trace_write_arbiter: round-robin write arbiter and circular trace buffer.
// Requesters hand completed records over valid/ready. Each accepted record
// is stamped with the cycle counter and source index, then stored. A host
// drains entries through the rd_* port.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   counter         free-running cycle count used as timestamp
//   enable, freeze  capture level / freeze pulse
//   req_valid/data  per-requester record handshake inputs
//   req_ready       one-hot grant (CAPTURE only)
//   rd_req          pop one entry
//   rd_valid/data/src/ts  popped entry, one cycle after rd_req
//   fill_level, full, empty, lost_count, state_o  status
//
// Build option: define TRACE_OVERWRITE_OLDEST_EN to overwrite the oldest
// entry when full instead of back-pressuring the requesters.
module trace_write_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int RECORD_WIDTH = 48,
    parameter int BUFFER_DEPTH = 16,
    parameter int TS_WIDTH     = 32,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [TS_WIDTH-1:0]             counter,
    input  logic                            enable,
    input  logic                            freeze,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*RECORD_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            rd_req,
    output logic                            rd_valid,
    output logic [RECORD_WIDTH-1:0]         rd_data,
    output logic [$clog2(NUM_REQ):0]        rd_src,
    output logic [TS_WIDTH-1:0]             rd_ts,
    output logic [$clog2(BUFFER_DEPTH):0]   fill_level,
    output logic                            full,
    output logic                            empty,
    output logic [CNT_WIDTH-1:0]            lost_count,
    output logic [1:0]                      state_o
);

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(NUM_REQ) + 1;
    localparam int EW = TS_WIDTH + SW + RECORD_WIDTH;

`ifdef TRACE_OVERWRITE_OLDEST_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FREEZE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]           rr_last_q, rr_last_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [RECORD_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [SW-1:0]           rd_src_q, rd_src_d;
    logic [TS_WIDTH-1:0]     rd_ts_q, rd_ts_d;
    logic [CNT_WIDTH-1:0]    lost_q, lost_d;
    logic [EW-1:0]           mem_q [BUFFER_DEPTH];

    logic                    full_w, empty_w;
    logic                    can_grant, xfer, rd_fire, lost_evt;
    logic [SW-1:0]           grant_idx;
    logic [RECORD_WIDTH-1:0] grant_data;
    logic [EW-1:0]           wr_entry, rd_entry;
    int                      idx;

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Grant decision uses the registered full flag, so a pop that frees a
    // slot only opens the write port on the following cycle.
    assign can_grant = (state_q == ST_CAPTURE) && (!full_w || OVW);

    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        xfer      = 1'b0;
        idx       = 0;
        if (can_grant) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(rr_last_q) + k) % NUM_REQ;
                if (!xfer && req_valid[idx]) begin
                    xfer           = 1'b1;
                    req_ready[idx] = 1'b1;
                    grant_idx      = SW'(idx);
                end
            end
        end
    end

    assign grant_data = req_data[grant_idx*RECORD_WIDTH +: RECORD_WIDTH];
    assign wr_entry   = {counter, grant_idx, grant_data};
    assign rd_fire    = rd_req && !empty_w;
    assign rd_entry   = mem_q[rd_ptr_q[AW-1:0]];

    // Full-cycle loss: a blocked request without overwrite, or an
    // overwrite of the oldest entry with it.
    assign lost_evt = (state_q == ST_CAPTURE) && (|req_valid) && full_w;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rr_last_d  = rr_last_q;
        rd_valid_d = rd_fire;
        rd_data_d  = rd_data_q;
        rd_src_d   = rd_src_q;
        rd_ts_d    = rd_ts_q;
        lost_d     = lost_q;

        if (rd_fire) begin
            {rd_ts_d, rd_src_d, rd_data_d} = rd_entry;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (xfer) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            rr_last_d = grant_idx;
            // Overwrite drops the oldest; a coincident pop already did.
            if (full_w && !rd_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end

        if (lost_evt && (lost_q != '1)) begin
            lost_d = lost_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (freeze)       state_d = ST_FREEZE;
                else if (!enable) state_d = ST_IDLE;
            end
            ST_FREEZE: begin
                if (empty_w && !rd_valid_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rr_last_q  <= SW'(NUM_REQ - 1);
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_src_q   <= '0;
            rd_ts_q    <= '0;
            lost_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rr_last_q  <= rr_last_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_src_q   <= rd_src_d;
            rd_ts_q    <= rd_ts_d;
            lost_q     <= lost_d;
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (rst_n && xfer) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_src     = rd_src_q;
    assign rd_ts      = rd_ts_q;
    assign fill_level = wr_ptr_q - rd_ptr_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign lost_count = lost_q;
    assign state_o    = state_q;

endmodule
